// File: rtl/fusion_pkg.sv
// fusion_pkg: shared fusion mode encodings and a hit-count popcount helper
package fusion_pkg;

    localparam logic [1:0] MODE_OVER    = 2'd0;
    localparam logic [1:0] MODE_IMAGE   = 2'd1;
    localparam logic [1:0] MODE_OVERLAY = 2'd2;
    localparam logic [1:0] MODE_INVERT  = 2'd3;

    // widest hit vector the popcount helper accepts; narrower vectors are zero-extended
    localparam int POP_MAX = 1024;

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX; i++) c += 32'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/fusion_lane.sv
// fusion_lane: combinational fusion of one image pixel with one overlay pixel
module fusion_lane
    import fusion_pkg::*;
#(
    parameter int               PIX_W = 8,
    parameter logic [PIX_W-1:0] KEY   = '0
) (
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] o,
    input  logic [1:0]       mode,
    output logic [PIX_W-1:0] out,
    output logic             hit
);

    logic is_key;

    assign is_key = (o == KEY);

    // select the fused pixel and flag whether the overlay supplied it
    always_comb begin
        out = (mode == MODE_OVER)    ? (is_key ? b : o) :
              (mode == MODE_IMAGE)   ? b :
              (mode == MODE_OVERLAY) ? o :
                                       (is_key ? b : ~b);
        hit = (mode == MODE_IMAGE)   ? 1'b0 :
              (mode == MODE_OVERLAY) ? 1'b1 :
                                       !is_key;
    end

endmodule

// File: rtl/fusion_stream.sv
// fusion_stream: two-stage valid/ready pipeline fusing image and overlay words per pixel
module fusion_stream
    import fusion_pkg::*;
#(
    parameter int               PIX_W = 8,
    parameter int               NPIX  = 64,
    parameter logic [PIX_W-1:0] KEY   = '0,
    parameter int               CNT_W = $clog2(NPIX + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [NPIX*PIX_W-1:0] image_data,
    input  logic [NPIX*PIX_W-1:0] overlay_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [NPIX*PIX_W-1:0] fusion_data,
    output logic [CNT_W-1:0]      hit_count
);

    localparam int W = NPIX * PIX_W;

    logic             v1_q, v1_d;
    logic [W-1:0]     img_q, img_d;
    logic [W-1:0]     ovl_q, ovl_d;
    logic [1:0]       mode_q, mode_d;
    logic             v2_q, v2_d;
    logic [W-1:0]     fus_q, fus_d;
    logic [CNT_W-1:0] hit_q, hit_d;

    logic             adv2;
    logic             in_xfer;
    logic             ld2;
    logic [W-1:0]     lane_out;
    logic [NPIX-1:0]  hit_vec;

    // stage 2 may advance when empty or draining; stage 1 may accept when it can pass its word on
    assign adv2    = !v2_q || m_ready;
    assign s_ready = !v1_q || adv2;
    assign in_xfer = s_valid && s_ready;
    assign ld2     = adv2 && v1_q;

    assign m_valid     = v2_q;
    assign fusion_data = fus_q;
    assign hit_count   = hit_q;

    for (genvar i = 0; i < NPIX; i++) begin : g_lane
        fusion_lane #(
            .PIX_W (PIX_W),
            .KEY   (KEY)
        ) u_lane (
            .b    (img_q[i*PIX_W +: PIX_W]),
            .o    (ovl_q[i*PIX_W +: PIX_W]),
            .mode (mode_q),
            .out  (lane_out[i*PIX_W +: PIX_W]),
            .hit  (hit_vec[i])
        );
    end

    // next state: stage 1 captures on input transfer, stage 2 takes stage 1 when it advances
    always_comb begin
        v1_d   = in_xfer || (v1_q && !adv2);
        img_d  = in_xfer ? image_data : img_q;
        ovl_d  = in_xfer ? overlay_data : ovl_q;
        mode_d = in_xfer ? mode : mode_q;
        v2_d   = adv2 ? v1_q : v2_q;
        fus_d  = ld2 ? lane_out : fus_q;
        hit_d  = ld2 ? CNT_W'(popcount(POP_MAX'(hit_vec))) : hit_q;
    end

    // pipeline registers; reset discards any in-flight words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            img_q  <= '0;
            ovl_q  <= '0;
            mode_q <= '0;
            v2_q   <= 1'b0;
            fus_q  <= '0;
            hit_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            img_q  <= img_d;
            ovl_q  <= ovl_d;
            mode_q <= mode_d;
            v2_q   <= v2_d;
            fus_q  <= fus_d;
            hit_q  <= hit_d;
        end
    end

endmodule
